ram512_arbiter: RTL

RAM512_ARBITER -- requirements
Module: ram512_arbiter

---
 rtl/ram512_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/ram512_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM512 macro.
// One access per two cycles: IDLE issues, RESP returns ack/rdata.
module ram512_arbiter #(
  parameter int BITS = 9
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [7:0]      p0_sel,
  input  logic [BITS-1:0] p0_addr,
  input  logic [63:0]     p0_wdata,
  output logic            p0_ack,
  output logic [63:0]     p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [7:0]      p1_sel,
  input  logic [BITS-1:0] p1_addr,
  input  logic [63:0]     p1_wdata,
  output logic            p1_ack,
  output logic [63:0]     p1_rdata,
  output logic            ram_en,
  output logic [7:0]      ram_we,
  output logic [BITS-1:0] ram_a,
  output logic [63:0]     ram_di,
  input  logic [63:0]     ram_do
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   win_q, win_d;
  logic   we_q, we_d;
  logic   any_req;
  logic   gnt;

  assign any_req = p0_req | p1_req;
  // On contention the port not granted last wins.
  assign gnt = (p0_req & p1_req) ? ~last_q : p1_req;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = RESP;
          win_d   = gnt;
          last_d  = gnt;
          we_d    = gnt ? p1_we : p0_we;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 8'h00;
    ram_a    = '0;
    ram_di   = 64'h0;
    p0_ack   = 1'b0;
    p1_ack   = 1'b0;
    p0_rdata = 64'h0;
    p1_rdata = 64'h0;
    unique case (state_q)
      IDLE: begin
        // Gated by RST_N so an in-flight reset blocks the RAM cycle.
        if (any_req && RST_N) begin
          ram_en = 1'b1;
          ram_a  = gnt ? p1_addr : p0_addr;
          ram_di = gnt ? p1_wdata : p0_wdata;
          if (gnt ? p1_we : p0_we)
            ram_we = gnt ? p1_sel : p0_sel;
        end
      end
      RESP: begin
        if (win_q) begin
          p1_ack = p1_req;
          if (p1_req && !we_q)
            p1_rdata = ram_do;
        end else begin
          p0_ack = p0_req;
          if (p0_req && !we_q)
            p0_rdata = ram_do;
        end
      end
      default: ;
    endcase
  end

endmodule
